// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and prescale limit helper for the APB timer
package timer_pkg;

    localparam logic [1:0] WR_SEL_NONE = 2'b00;
    localparam logic [1:0] WR_SEL_TDR0 = 2'b01;
    localparam logic [1:0] WR_SEL_TDR1 = 2'b10;

    localparam int DIV_VAL_MAX = 8;

    localparam logic [7:0] ADDR_TCR  = 8'h00;
    localparam logic [7:0] ADDR_TDR0 = 8'h04;
    localparam logic [7:0] ADDR_TDR1 = 8'h08;
    localparam logic [7:0] ADDR_TCMP0 = 8'h0C;
    localparam logic [7:0] ADDR_TCMP1 = 8'h10;
    localparam logic [7:0] ADDR_TIER = 8'h14;
    localparam logic [7:0] ADDR_TISR = 8'h18;

    // Prescale limit 2^div_val - 1; exponents above the maximum saturate at the maximum.
    function automatic logic [7:0] div_limit(input logic [7:0] dv);
        logic [3:0] expo;
        logic [8:0] span;
        expo = (dv > 8'(DIV_VAL_MAX)) ? 4'(DIV_VAL_MAX) : dv[3:0];
        span = (9'd1 << expo) - 9'd1;
        return span[7:0];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - power-of-two prescaler producing the counter tick
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             act,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             clr,
    output logic             tick
);

    logic [7:0] div_cnt;
    logic [7:0] limit;
    logic       at_limit;

    assign limit    = div_limit(8'(div_val));
    assign at_limit = (div_cnt == limit);

    // Without the prescaler every active cycle ticks; with it only the limit cycle does.
    assign tick = act & (~div_en | at_limit);

    // Phase counter: cleared on clear or bypass, advanced only while active, frozen otherwise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= 8'd0;
        end else if (clr || !div_en) begin
            div_cnt <= 8'd0;
        end else if (act) begin
            div_cnt <= at_limit ? 8'd0 : div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - 64-bit timer count stage with prescaler, halt and half loads
module timer_counter
    import timer_pkg::*;
#(
    parameter int CNT_W = 64,
    parameter int DIV_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             halt_req,
    input  logic             timer_en_out,
    input  logic [1:0]       wr_sel,
    input  logic [31:0]      wdt,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_tick
);

    logic act;
    logic wr_lo;
    logic wr_hi;
    logic wr_any;
    logic clr;
    logic tick;

    assign act    = timer_en & ~halt_req;
    assign wr_lo  = (wr_sel == WR_SEL_TDR0);
    assign wr_hi  = (wr_sel == WR_SEL_TDR1);
    assign wr_any = wr_lo | wr_hi;
    // A software load outranks the clear, so the prescaler phase survives a load cycle.
    assign clr    = timer_en_out & ~wr_any;

    timer_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .act      (act),
        .div_en   (div_en),
        .div_val  (div_val),
        .clr      (clr),
        .tick     (tick)
    );

    // Counter update in priority order: low load, high load, clear, increment, hold.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt[31:0] <= wdt;
        end else if (wr_hi) begin
            cnt[CNT_W-1:32] <= (CNT_W-32)'(wdt);
        end else if (timer_en_out) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Tick pulse marks a cycle whose increment actually landed in the counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_tick <= 1'b0;
        end else begin
            cnt_tick <= tick & ~wr_any & ~timer_en_out;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter with a behavioural model
module tb_timer_counter;
    import timer_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        timer_en = 1'b0;
    logic        div_en = 1'b0;
    logic [3:0]  div_val = 4'd0;
    logic        halt_req = 1'b0;
    logic        timer_en_out = 1'b0;
    logic [1:0]  wr_sel = 2'b00;
    logic [31:0] wdt = 32'd0;
    logic [63:0] cnt;
    logic        cnt_tick;

    always #5 sys_clk = ~sys_clk;

    timer_counter #(
        .CNT_W(64),
        .DIV_W(4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .timer_en    (timer_en),
        .div_en      (div_en),
        .div_val     (div_val),
        .halt_req    (halt_req),
        .timer_en_out(timer_en_out),
        .wr_sel      (wr_sel),
        .wdt         (wdt),
        .cnt         (cnt),
        .cnt_tick    (cnt_tick)
    );

    typedef struct {
        logic [63:0] cnt;
        logic        tick;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    string tag = "reset";

    longint unsigned m_cnt = 0;
    int              m_phase = 0;
    bit              m_tick = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model: advance one clock from the present inputs, queue the expected outputs, then clock.
    task automatic cycle();
        int  lim;
        int  dv;
        bit  act;
        bit  wr;
        bit  tk;
        if (!sys_rst_n) begin
            m_cnt = 0;
            m_phase = 0;
            m_tick = 0;
        end else begin
            dv  = (int'(div_val) > 8) ? 8 : int'(div_val);
            lim = (1 << dv) - 1;
            wr  = (wr_sel == 2'b01) || (wr_sel == 2'b10);
            act = timer_en && !halt_req;
            tk  = 0;
            if (timer_en_out && !wr) begin
                m_phase = 0;
            end else if (!div_en) begin
                m_phase = 0;
                tk = act;
            end else if (act) begin
                if (m_phase == lim) begin
                    tk = 1;
                    m_phase = 0;
                end else begin
                    m_phase = (m_phase + 1) % 256;
                end
            end
            if (wr_sel == 2'b01)
                m_cnt = {m_cnt[63:32], wdt};
            else if (wr_sel == 2'b10)
                m_cnt = {wdt, m_cnt[31:0]};
            else if (timer_en_out)
                m_cnt = 0;
            else if (tk)
                m_cnt = m_cnt + 1;
            m_tick = tk && !wr && !timer_en_out;
        end
        sb.push_back('{cnt: m_cnt, tick: m_tick, tag: tag});
        @(posedge sys_clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_cnt();
        timer_en = 1'b0;
        timer_en_out = 1'b1;
        wr_sel = 2'b00;
        cycle();
        timer_en_out = 1'b0;
    endtask

    // Monitor: the DUT presents a new count every clock; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (cnt !== e.cnt || cnt_tick !== e.tick) begin
                    miscompares++;
                    $display("FAIL %s: cnt=%h tick=%b, expected cnt=%h tick=%b",
                             e.tag, cnt, cnt_tick, e.cnt, e.tick);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_en;
        int r;

        @(posedge sys_clk);
        #2;
        run(2);
        check("reset_cnt", cnt, 64'd0);
        check("reset_tick", {63'd0, cnt_tick}, 64'd0);
        sys_rst_n = 1'b1;

        tag = "load_1234";
        wr_sel = WR_SEL_TDR0; wdt = 32'h1234;
        cycle();
        check("load_1234", cnt, 64'h1234);
        wr_sel = 2'b00; timer_en = 1'b1;
        tag = "count_pre_reset";
        run(2);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_cnt", cnt, 64'd0);
        check("async_reset_tick", {63'd0, cnt_tick}, 64'd0);
        tag = "in_reset";
        timer_en = 1'b0;
        cycle();
        sys_rst_n = 1'b1;
        timer_en = 1'b1;
        tag = "count_after_reset";
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("count_after_reset", cnt, 64'(i));
        end

        tag = "div3";
        clear_cnt();
        div_en = 1'b1; div_val = 4'd3; timer_en = 1'b1;
        run(40);
        check("div3_40cyc", cnt, 64'd5);

        tag = "div8";
        clear_cnt();
        div_val = 4'd8; timer_en = 1'b1;
        run(512);
        check("div8_512cyc", cnt, 64'd2);

        tag = "div0";
        clear_cnt();
        div_val = 4'd0; timer_en = 1'b1;
        run(4);
        check("div0_4cyc", cnt, 64'd4);

        tag = "halt";
        clear_cnt();
        div_val = 4'd3; timer_en = 1'b1;
        run(5);
        halt_req = 1'b1;
        run(20);
        check("halt_frozen", cnt, 64'd0);
        halt_req = 1'b0;
        run(2);
        check("halt_resume_2", cnt, 64'd0);
        cycle();
        check("halt_resume_3", cnt, 64'd1);

        tag = "wrap";
        div_en = 1'b0;
        wr_sel = WR_SEL_TDR0; wdt = 32'hFFFF_FFFF;
        cycle();
        wr_sel = WR_SEL_TDR1;
        cycle();
        check("load_all_ones", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_sel = 2'b00;
        cycle();
        check("wrap_to_zero", cnt, 64'd0);

        tag = "clear_prio";
        wr_sel = WR_SEL_TDR0; wdt = 32'h55;
        cycle();
        wr_sel = WR_SEL_TDR1; wdt = 32'h0;
        cycle();
        check("load_55", cnt, 64'h55);
        clear_cnt();
        check("clear_55", cnt, 64'd0);
        wr_sel = WR_SEL_TDR1; wdt = 32'h77;
        cycle();
        wr_sel = 2'b00; timer_en = 1'b1;
        cycle();
        timer_en = 1'b0; timer_en_out = 1'b1;
        wr_sel = WR_SEL_TDR0; wdt = 32'hA5;
        cycle();
        timer_en_out = 1'b0; wr_sel = 2'b00;
        check("load_beats_clear", cnt, 64'h0000_0077_0000_00A5);

        tag = "carry";
        timer_en = 1'b1;
        wr_sel = WR_SEL_TDR1; wdt = 32'h0;
        cycle();
        wr_sel = WR_SEL_TDR0; wdt = 32'hFFFF_FFFF;
        cycle();
        check("load_low_ones", cnt, 64'h0000_0000_FFFF_FFFF);
        wr_sel = 2'b00;
        cycle();
        check("carry_into_high", cnt, 64'h0000_0001_0000_0000);
        wr_sel = 2'b11; wdt = 32'hDEAD_BEEF;
        cycle();
        check("illegal_wr_sel", cnt, 64'h0000_0001_0000_0001);
        wr_sel = 2'b00;

        tag = "random";
        prev_en = timer_en;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) timer_en = ~timer_en;
            timer_en_out = prev_en & ~timer_en;
            prev_en = timer_en;
            halt_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) div_en = ~div_en;
            if ($urandom_range(0, 99) == 0) div_val = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 15);
            wr_sel = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            wdt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            cycle();
        end
        timer_en_out = 1'b0;
        wr_sel = 2'b00;
        halt_req = 1'b0;

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Counting stage of the APB timer: a 64-bit up-counter with a power-of-two prescaler, debug halt, and software-loadable halves. It sits directly downstream of the timer register block. It consumes that block's control outputs (`timer_en`, `div_en`, `div_val`, `halt_req`, `timer_en_out`, `wr_sel`, `wdt`) and returns `cnt[63:0]`, which feeds TDR0/TDR1 readback and the compare interrupt logic.

## Interface
- `CNT_W`, default 64: counter width; must be 64 for TDR0/TDR1 mapping.
- `DIV_W`, default 4: width of `div_val`; legal values are 0..8.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset; asynchronous, active-low; clock `sys_clk`.
- `timer_en`  in  1  counting enable (TCR[0], next-state value).
- `div_en`  in  1  prescaler enable (TCR[1]).
- `div_val`  in  4  prescale exponent; tick period is 2^div_val cycles.
- `halt_req`  in  1  debug halt acknowledged; freezes all counting state.
- `timer_en_out`  in  1  one-cycle pulse on timer_en 1→0; clears counter and prescaler.
- `wr_sel`  in  2  01 loads `cnt[31:0]`; 10 loads `cnt[63:32]`; 00 and 11 mean no write.
- `wdt`  in  32  load data for the selected half.
- `cnt`  out  64  current counter value; reset value 0.
- `cnt_tick`  out  1  registered pulse, high for the cycle after an increment; reset value 0.

## Operation
- **Prescaler.** An 8-bit `div_cnt` with limit L = 2^div_val − 1 (0..255).
- **Count-active condition.** `act = timer_en & ~halt_req`.
- **Tick generation.**
  - `div_en=0`: `tick = act` on every cycle; `div_cnt` is held at 0.
  - `div_en=1`, `act=1`: if `div_cnt == L`, then `tick=1` and `div_cnt` becomes 0; otherwise `div_cnt` increments and `tick=0`.
  - `div_en=1`, `div_val=0`: L = 0, so a tick occurs every cycle.
  - `act=0` because `timer_en=0`: `div_cnt` is held, `tick=0`.
  - `act=0` because `halt_req=1`: `div_cnt` and `cnt` are both frozen, not cleared.
- **Out-of-range `div_val`.** `div_val > 8` is treated as 8. The register block already blocks such writes; this clamp is the defensive behaviour.
- **Counter update priority (highest first):**
  1. `wr_sel==01`: `cnt[31:0] <= wdt`, upper half held, no increment this cycle.
  2. `wr_sel==10`: `cnt[63:32] <= wdt`, lower half held, no increment this cycle.
  3. `timer_en_out`: `cnt <= 0` and `div_cnt <= 0`.
  4. `tick`: `cnt <= cnt + 1`, full 64-bit carry; wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
  5. Otherwise `cnt` is held.
- **Writes and the prescaler.** A write does not clear `div_cnt`. `div_cnt` still advances on a write cycle if `act`, but any tick produced on that cycle is dropped.
- **Illegal `wr_sel` (11).** Ignored: treated as no write, and counting proceeds normally.
- **Reset mid-count.** Reset asynchronously forces `cnt=0`, `div_cnt=0`, `cnt_tick=0`.

## Timing
- All state is registered on the `sys_clk` rising edge. There is no combinational path from inputs to `cnt`.
- **Write latency.** `wr_sel`/`wdt` valid in cycle T → new value on `cnt` in T+1. This matches an APB write completing in the access phase of cycle T, so a read of TDR in T+1 returns the written value.
- **Enable latency.**
  - `timer_en` rising in cycle T with `div_en=0` → `cnt` increments at the end of T and shows +1 in T+1.
  - With `div_en=1`, the first increment is visible in T+L+1, then every L+1 cycles.
- **Clear latency.** `timer_en_out` in cycle T → `cnt == 0` in T+1.
- **Halt.**
  - `halt_req` high in T: no change to `cnt`/`div_cnt` at the end of T.
  - Resuming: counting continues from the frozen `div_cnt` phase.
- **`cnt_tick` timing.** `cnt_tick` in T+1 corresponds to the increment performed at the end of T.

## Structure
- **Shared package `timer_pkg`:**
  - `WR_SEL_TDR0` = 2'b01, `WR_SEL_TDR1` = 2'b10.
  - `DIV_VAL_MAX` = 8.
  - Limit function `div_limit(div_val)` returning 8 bits, with the clamp.
  - Register address constants, shared with the register block.
- **Sub-module `timer_prescaler`:**
  - Inputs: `sys_clk`, `sys_rst_n`, `act`, `div_en`, `div_val`, `clr`.
  - Output: `tick`.
  - Contains `div_cnt`.
- **Top level.** Holds the 64-bit counter, the priority mux, and the `cnt_tick` register.

## Test plan
- **Reset.** Assert `sys_rst_n=0` mid-count with `cnt=0x1234` → `cnt=0` and `cnt_tick=0` immediately (asynchronous). Release, `timer_en=1`, `div_en=0` → `cnt=1,2,3` on consecutive cycles.
- **Prescaler.** `div_en=1`, `div_val=3`, `timer_en=1` for 40 cycles → `cnt=5`, with ticks spaced exactly 8 cycles apart. `div_val=8` over 512 cycles → `cnt=2`. `div_val=0` → increment every cycle.
- **Halt.** Halt mid-prescale at `div_cnt=5` (`div_val=3`) for 20 cycles → `cnt` and phase are frozen; after release the next tick arrives 3 cycles later.
- **Loads and wrap.** `wr_sel=01`, `wdt=0xFFFF_FFFF`, then `wr_sel=10`, `wdt=0xFFFF_FFFF` while counting → `cnt=0xFFFF_FFFF_FFFF_FFFF` in the next cycle with no increment on either write cycle; the following tick gives `cnt=0`.
- **Clear and priority.** `timer_en` 1→0 with `cnt=0x55` → `timer_en_out` pulse → `cnt=0` the next cycle. Pulse `timer_en_out` together with `wr_sel=01`, `wdt=0xA5` → `cnt[31:0]=0xA5`, and the upper half is held.
- **Carry.** Load `cnt=0x0000_0000_FFFF_FFFF`, tick once → `cnt=0x0000_0001_0000_0000`. `wr_sel=11` → `cnt` is unchanged by the write and counting continues.
